wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the pipelined CPU: holds the MEM/WB pipeline register, formats load data (byte/halfword extract, sign/zero extend), selects the register-file write source and drives the register file's write port (`RFWr`, `WrDtAdr`, `WrDt`). It sits directly upstream of the register file, which writes on the falling edge. This block captures on the rising edge, so a result retires in the same cycle it leaves this stage. It also keeps a retired-instruction counter.

## Interface
- `RST_PC`, 32'h0000_0000: reset value of the registered PC field.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low (state cleared on a rising edge while `rst`=0).
- `stall`  in  1  hold the MEM/WB register.
- `flush`  in  1  load a bubble into the MEM/WB register.
- `mem_valid`  in  1  MEM stage holds a real instruction.
- `mem_RFWr`  in  1  instruction writes `rd`.
- `mem_rd`  in  5  destination register.
- `mem_WDSel`  in  2  write source: 00 ALU, 01 load data, 10 PC+4, 11 reserved (treated as ALU).
- `mem_DMType`  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; other codes behave as lw.
- `mem_alu_out`  in  32  ALU result; for loads, the effective address.
- `mem_rdata`  in  32  raw aligned data-memory word.
- `mem_pc`  in  32  instruction PC.
- `RFWr`  out  1  register-file write enable.
- `WrDtAdr`  out  5  register-file write address.
- `WrDt`  out  32  register-file write data.
- `wb_valid`  out  1  the MEM/WB register holds a real instruction (used by forwarding/hazard logic).
- `ld_misalign`  out  1  the held load is misaligned.
- `instret`  out  64  retired-instruction count.

## Operation
- MEM/WB register fields: valid, RFWr, rd, WDSel, DMType, alu_out, rdata, pc.
- Update priority on each rising edge: `rst`=0, then `flush`, then `stall`, then load.
  - Reset: all fields 0, except pc = `RST_PC`.
  - Flush: valid = 0. Other fields are don't-care but must be set to 0.
  - Stall: hold all fields.
  - Otherwise: capture the `mem_*` inputs.
- Load extract uses offset = alu_out[1:0].
  - lb/lbu select byte `offset`; lh/lhu select halfword `offset[1]`; lw selects the full word.
  - lb and lh sign-extend; lbu and lhu zero-extend.
- Misalignment:
  - `ld_misalign` = valid & WDSel==01 & one of: lh/lhu with offset[0]=1, or lw with offset≠0.
  - A misaligned load does not write.
- Write data before gating:
  - WDSel 00/11: alu_out.
  - WDSel 01: extracted load data.
  - WDSel 10: pc+4, modulo 2^32.
- `RFWr` = valid & RFWr field & rd≠0 & !`ld_misalign`.
- When `RFWr`=0, `WrDtAdr` and `WrDt` must both be 0. This is mandatory: the register file bypasses `WrDt` on an address match without checking `RFWr`, and address 0 is hard-wired to return 0.
- `instret` increments by 1 on each rising edge where valid=1, `stall`=0 and `rst`=1.
  - A flush on the same edge still counts the instruction that is leaving.
  - The count wraps from 2^64−1 to 0.
  - Misaligned loads and writes to x0 still count as retired.

## Timing
- Latency: one cycle. Inputs captured on rising edge N drive `RFWr`/`WrDt` during cycle N, and the register file commits on the falling edge of cycle N.
- All outputs are combinational from registered state only. There is no combinational path from any `mem_*` input, `stall` or `flush` to any output.
- Values while `rst` is held at 0 (after the edge): `RFWr`=0, `WrDtAdr`=0, `WrDt`=0, `wb_valid`=0, `ld_misalign`=0, `instret`=0.
- Stalled instruction: `RFWr` stays asserted for every stalled cycle. Rewriting the same value is idempotent and permitted.
- Reset asserted mid-stall: reset wins and the held instruction is dropped without counting.

## Structure
- Package `wb_pkg`:
  - WDSel constants: `WD_ALU`, `WD_MEM`, `WD_PC`.
  - DMType constants: `DM_WORD`, `DM_HALF`, `DM_HALF_U`, `DM_BYTE`, `DM_BYTE_U`.
  - Shared with the control unit and data-memory interface.
- Sub-module `load_ext`: purely combinational (DMType, offset, rdata → data, misalign). Reused by any future load-forwarding path.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `mem_valid`=1 → `RFWr`=0, `WrDtAdr`=0, `WrDt`=0, `instret`=0.
- ALU write: valid, RFWr, rd=5, WDSel=00, alu_out=32'h1234_5678 → next cycle `RFWr`=1, `WrDtAdr`=5, `WrDt`=32'h1234_5678, `instret`=1.
- Loads with rdata=32'h80FF_7F01:
  - lb offset 2 → 32'hFFFF_FFFF.
  - lbu offset 3 → 32'h0000_0080.
  - lh offset 2 → 32'hFFFF_80FF.
  - lhu offset 0 → 32'h0000_7F01.
  - lw offset 1 → `ld_misalign`=1, `RFWr`=0, `WrDtAdr`=0.
- JAL link: WDSel=10, pc=32'hFFFF_FFFC, rd=1 → `WrDt`=32'h0000_0000. Same instruction with rd=0 → `RFWr`=0, `WrDtAdr`=0, `WrDt`=0.
- Stall/flush:
  - Stall for 3 cycles → outputs held, `instret` increments once, on release.
  - `flush` and `stall` on the same edge → bubble, `wb_valid`=0.
- Counter wrap: preload `instret`=2^64−1, retire one instruction → `instret`=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage, control unit and data-memory interface.
package wb_pkg;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef struct packed {
    logic        valid;
    logic        rfWr;
    logic [4:0]  rd;
    logic [1:0]  wdSel;
    logic [2:0]  dmType;
    logic [31:0] aluOut;
    logic [31:0] rdata;
    logic [31:0] pc;
  } memWbT;

endpackage

// File: rtl/load_ext.sv
// Load data formatting: byte/halfword extract with sign/zero extension plus alignment check.
module load_ext
  import wb_pkg::*;
(
  input  logic [2:0]  dmType,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    case (offset)
      2'd0:    byteSel = rdata[7:0];
      2'd1:    byteSel = rdata[15:8];
      2'd2:    byteSel = rdata[23:16];
      default: byteSel = rdata[31:24];
    endcase
    halfSel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  // Unknown DMType codes fall through to word behaviour.
  always_comb begin
    data     = rdata;
    misalign = (offset != 2'd0);
    case (dmType)
      DM_HALF: begin
        data     = {{16{halfSel[15]}}, halfSel};
        misalign = offset[0];
      end
      DM_HALF_U: begin
        data     = {16'h0000, halfSel};
        misalign = offset[0];
      end
      DM_BYTE: begin
        data     = {{24{byteSel[7]}}, byteSel};
        misalign = 1'b0;
      end
      DM_BYTE_U: begin
        data     = {24'h000000, byteSel};
        misalign = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, write-source select and register-file write port driver.
// Also keeps the 64-bit retired-instruction counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter logic [31:0] RST_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_RFWr,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_WDSel,
  input  logic [2:0]  mem_DMType,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] mem_pc,
  output logic        RFWr,
  output logic [4:0]  WrDtAdr,
  output logic [31:0] WrDt,
  output logic        wb_valid,
  output logic        ld_misalign,
  output logic [63:0] instret
);

  memWbT       wbQ;
  logic [63:0] instretCnt;
  logic [31:0] loadData;
  logic        loadMisalign;
  logic [31:0] wrDataRaw;
  logic        wrEn;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wbQ    <= '0;
      wbQ.pc <= RST_PC;
    end else if (flush) begin
      wbQ <= '0;
    end else if (!stall) begin
      wbQ.valid  <= mem_valid;
      wbQ.rfWr   <= mem_RFWr;
      wbQ.rd     <= mem_rd;
      wbQ.wdSel  <= mem_WDSel;
      wbQ.dmType <= mem_DMType;
      wbQ.aluOut <= mem_alu_out;
      wbQ.rdata  <= mem_rdata;
      wbQ.pc     <= mem_pc;
    end
  end

  // The departing instruction counts even when a flush lands on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instretCnt <= '0;
    end else if (wbQ.valid && !stall) begin
      instretCnt <= instretCnt + 64'd1;
    end
  end

  load_ext uLoadExt (
    .dmType   (wbQ.dmType),
    .offset   (wbQ.aluOut[1:0]),
    .rdata    (wbQ.rdata),
    .data     (loadData),
    .misalign (loadMisalign)
  );

  always_comb begin
    case (wbQ.wdSel)
      WD_MEM:  wrDataRaw = loadData;
      WD_PC:   wrDataRaw = wbQ.pc + 32'd4;
      default: wrDataRaw = wbQ.aluOut;
    endcase
  end

  assign ld_misalign = wbQ.valid && (wbQ.wdSel == WD_MEM) && loadMisalign;
  assign wrEn        = wbQ.valid && wbQ.rfWr && (wbQ.rd != 5'd0) && !ld_misalign;

  // The register file bypasses WrDt on address match regardless of RFWr, so idle must be all-zero.
  assign RFWr     = wrEn;
  assign WrDtAdr  = wrEn ? wbQ.rd : 5'd0;
  assign WrDt     = wrEn ? wrDataRaw : 32'd0;
  assign wb_valid = wbQ.valid;
  assign instret  = instretCnt;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a spec-level reference model checked every cycle.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        mem_valid, mem_RFWr;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_WDSel;
  logic [2:0]  mem_DMType;
  logic [31:0] mem_alu_out, mem_rdata, mem_pc;
  logic        RFWr, wb_valid, ld_misalign;
  logic [4:0]  WrDtAdr;
  logic [31:0] WrDt;
  logic [63:0] instret;

  int nCmp = 0;
  int nBad = 0;
  logic chkOn = 1'b0;

  // Model of the held instruction and the number of retirements seen.
  logic        mValid, mRfWr;
  logic [4:0]  mRd;
  logic [1:0]  mWd;
  logic [2:0]  mDm;
  logic [31:0] mAlu, mRdata, mPc;
  logic [63:0] mCnt;
  logic [63:0] cntBias = 64'd0;

  wb_stage #(.RST_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_RFWr(mem_RFWr), .mem_rd(mem_rd),
    .mem_WDSel(mem_WDSel), .mem_DMType(mem_DMType), .mem_alu_out(mem_alu_out),
    .mem_rdata(mem_rdata), .mem_pc(mem_pc),
    .RFWr(RFWr), .WrDtAdr(WrDtAdr), .WrDt(WrDt), .wb_valid(wb_valid),
    .ld_misalign(ld_misalign), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      mValid = 0; mRfWr = 0; mRd = 0; mWd = 0; mDm = 0;
      mAlu = 0; mRdata = 0; mPc = 0; mCnt = 0;
    end else begin
      if (mValid && !stall) mCnt = mCnt + 1;
      if (flush) begin
        mValid = 0; mRfWr = 0; mRd = 0; mWd = 0; mDm = 0;
        mAlu = 0; mRdata = 0; mPc = 0;
      end else if (!stall) begin
        mValid = mem_valid; mRfWr = mem_RFWr; mRd = mem_rd; mWd = mem_WDSel;
        mDm = mem_DMType; mAlu = mem_alu_out; mRdata = mem_rdata; mPc = mem_pc;
      end
    end
  end

  always @(negedge clk) begin
    if (chkOn) begin
      int unsigned off, bytev, halfv;
      logic [31:0] ld, data;
      logic mis, we;
      off   = int'(mAlu & 32'd3);
      bytev = (mRdata >> (8 * off)) & 32'hFF;
      halfv = (mRdata >> (16 * (off / 2))) & 32'hFFFF;
      case (mDm)
        3'd3:    ld = (bytev >= 128) ? (bytev | 32'hFFFF_FF00) : bytev;
        3'd4:    ld = bytev;
        3'd1:    ld = (halfv >= 32768) ? (halfv | 32'hFFFF_0000) : halfv;
        3'd2:    ld = halfv;
        default: ld = mRdata;
      endcase
      if (mDm == 3'd1 || mDm == 3'd2) mis = (off % 2) != 0;
      else if (mDm == 3'd3 || mDm == 3'd4) mis = 1'b0;
      else mis = (off != 0);
      mis  = mValid && (mWd == 2'd1) && mis;
      data = (mWd == 2'd1) ? ld : (mWd == 2'd2) ? mPc + 32'd4 : mAlu;
      we   = mValid && mRfWr && (mRd != 0) && !mis;
      chk("m_RFWr", RFWr, we);
      chk("m_WrDtAdr", WrDtAdr, we ? mRd : 5'd0);
      chk("m_WrDt", WrDt, we ? data : 32'd0);
      chk("m_wb_valid", wb_valid, mValid);
      chk("m_ld_misalign", ld_misalign, mis);
      chk("m_instret", instret, mCnt + cntBias);
    end
  end

  task automatic drive(input logic v, input logic w, input logic [4:0] rd, input logic [1:0] wd,
                       input logic [2:0] dm, input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [31:0] pc);
    mem_valid = v; mem_RFWr = w; mem_rd = rd; mem_WDSel = wd;
    mem_DMType = dm; mem_alu_out = alu; mem_rdata = rdat; mem_pc = pc;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F01;

  initial begin
    rst = 0; stall = 0; flush = 0;
    drive(1, 1, 5'd4, 2'b00, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'h100);
    @(posedge clk);
    chkOn = 1'b1;
    @(negedge clk);
    cyc();
    chk("rst_RFWr", RFWr, 0);
    chk("rst_WrDtAdr", WrDtAdr, 0);
    chk("rst_WrDt", WrDt, 0);
    chk("rst_instret", instret, 0);
    rst = 1;

    drive(1, 1, 5'd5, 2'b00, 3'd0, 32'h1234_5678, 32'd0, 32'h200); cyc();
    chk("alu_RFWr", RFWr, 1);
    chk("alu_WrDtAdr", WrDtAdr, 5);
    chk("alu_WrDt", WrDt, 32'h1234_5678);

    drive(1, 1, 5'd6, 2'b01, 3'd3, 32'h1000_0002, RD, 32'h204); cyc();
    chk("lb_WrDt", WrDt, 32'hFFFF_FFFF);
    chk("alu_instret", instret, 1);
    drive(1, 1, 5'd6, 2'b01, 3'd4, 32'h1000_0003, RD, 32'h208); cyc();
    chk("lbu_WrDt", WrDt, 32'h0000_0080);
    drive(1, 1, 5'd6, 2'b01, 3'd1, 32'h1000_0002, RD, 32'h20C); cyc();
    chk("lh_WrDt", WrDt, 32'hFFFF_80FF);
    drive(1, 1, 5'd6, 2'b01, 3'd2, 32'h1000_0000, RD, 32'h210); cyc();
    chk("lhu_WrDt", WrDt, 32'h0000_7F01);
    drive(1, 1, 5'd6, 2'b01, 3'd0, 32'h1000_0001, RD, 32'h214); cyc();
    chk("lw_mis", ld_misalign, 1);
    chk("lw_mis_RFWr", RFWr, 0);
    chk("lw_mis_WrDtAdr", WrDtAdr, 0);
    drive(1, 1, 5'd1, 2'b10, 3'd0, 32'h0, 32'd0, 32'hFFFF_FFFC); cyc();
    chk("jal_RFWr", RFWr, 1);
    chk("jal_WrDt", WrDt, 32'h0000_0000);
    drive(1, 1, 5'd0, 2'b10, 3'd0, 32'h0, 32'd0, 32'hFFFF_FFFC); cyc();
    chk("x0_RFWr", RFWr, 0);
    chk("x0_WrDtAdr", WrDtAdr, 0);
    chk("x0_WrDt", WrDt, 0);
    chk("x0_instret", instret, 7);

    drive(1, 1, 5'd7, 2'b00, 3'd0, 32'hAAAA_0000, 32'd0, 32'h300); cyc();
    stall = 1;
    drive(1, 1, 5'd9, 2'b00, 3'd0, 32'h9999_9999, 32'd0, 32'h304);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_RFWr", RFWr, 1);
      chk("stall_WrDtAdr", WrDtAdr, 7);
      chk("stall_WrDt", WrDt, 32'hAAAA_0000);
      chk("stall_instret", instret, 8);
    end
    stall = 0;
    drive(0, 0, 5'd0, 2'b00, 3'd0, 32'h0, 32'd0, 32'h0); cyc();
    chk("unstall_instret", instret, 9);

    drive(1, 1, 5'd3, 2'b00, 3'd0, 32'h33, 32'd0, 32'h400); cyc();
    flush = 1; stall = 1; cyc();
    chk("flst_wb_valid", wb_valid, 0);
    chk("flst_RFWr", RFWr, 0);
    flush = 0; stall = 0;
    drive(1, 1, 5'd10, 2'b00, 3'd0, 32'h10, 32'd0, 32'h500); cyc();
    flush = 1; cyc();
    chk("flush_wb_valid", wb_valid, 0);
    chk("flush_instret", instret, 10);
    flush = 0;

    drive(1, 1, 5'd11, 2'b00, 3'd0, 32'h11, 32'd0, 32'h600); cyc();
    stall = 1; cyc();
    rst = 0; cyc();
    chk("rststall_instret", instret, 0);
    chk("rststall_wb_valid", wb_valid, 0);
    rst = 1; stall = 0;

    drive(1, 1, 5'd12, 2'b00, 3'd0, 32'h5, 32'd0, 32'h700); cyc();
    stall = 1;
    @(posedge clk);
    #2;
    force dut.instretCnt = 64'hFFFF_FFFF_FFFF_FFFF;
    release dut.instretCnt;
    cntBias = 64'hFFFF_FFFF_FFFF_FFFF - mCnt;
    @(negedge clk);
    chk("wrap_pre", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    stall = 0;
    drive(0, 0, 5'd0, 2'b00, 3'd0, 32'h0, 32'd0, 32'h0); cyc();
    chk("wrap_post", instret, 64'd0);
    cyc();

    chkOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
